rs_degree_scan: RTL and testbench

//   Sequential, parametrised polynomial-degree finder for the RS decoder
//   (error-locator / evaluator degree). Captures a flattened coefficient vector
//   on start, then scans LANES coefficients per cycle from the top down, with

---
 rtl/rs_degree_scan.sv | 114 +++++++++++
 tb/tb_rs_degree_scan.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_degree_scan.sv
// Sequential polynomial-degree finder: captures the coefficients on start, then
// scans LANES coefficients per cycle from the top group down, exiting at the first non-zero group.
module rs_degree_scan #(
    parameter int SYM_W = 6,
    parameter int NCOEF = 20,
    parameter int LANES = 4,
    parameter int DEG_W = 5
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   enable,
    input  logic                   start,
    input  logic [NCOEF*SYM_W-1:0] polynom_in,
    output logic                   busy,
    output logic                   done,
    output logic [DEG_W-1:0]       degree,
    output logic                   zero_poly
);

    localparam int NGRP  = (NCOEF + LANES - 1) / LANES;
    localparam int PTR_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [PTR_W-1:0]         r_ptr;
    logic [PTR_W-1:0]         w_ptrNext;
    logic [NCOEF*SYM_W-1:0]   r_poly;
    logic                     w_capture;
    logic                     w_doneNext;
    logic [DEG_W-1:0]         w_degNext;
    logic                     w_zeroNext;
    logic                     w_hit;
    logic [DEG_W-1:0]         w_hitDeg;

    assign busy = (r_state == SCAN);

    // Later lanes overwrite earlier ones, so the highest non-zero index wins; pad lanes are skipped.
    always_comb begin
        int idx;
        idx      = 0;
        w_hit    = 1'b0;
        w_hitDeg = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = int'(r_ptr) * LANES + l;
            if (idx < NCOEF) begin
                if (r_poly[idx*SYM_W +: SYM_W] != '0) begin
                    w_hit    = 1'b1;
                    w_hitDeg = DEG_W'(idx);
                end
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_capture   = 1'b0;
        w_doneNext  = 1'b0;
        w_degNext   = degree;
        w_zeroNext  = zero_poly;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_ptrNext   = PTR_W'(NGRP - 1);
                    w_stateNext = SCAN;
                end
            end
            SCAN: begin
                if (w_hit) begin
                    w_degNext   = w_hitDeg;
                    w_zeroNext  = 1'b0;
                    w_doneNext  = 1'b1;
                    w_stateNext = IDLE;
                end else if (r_ptr == '0) begin
                    w_degNext   = '0;
                    w_zeroNext  = 1'b1;
                    w_doneNext  = 1'b1;
                    w_stateNext = IDLE;
                end else begin
                    w_ptrNext = r_ptr - PTR_W'(1);
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // With enable low every register, including the done pulse, simply holds.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_poly    <= '0;
            done      <= 1'b0;
            degree    <= '0;
            zero_poly <= 1'b0;
        end else if (enable) begin
            r_state   <= w_stateNext;
            r_ptr     <= w_ptrNext;
            done      <= w_doneNext;
            degree    <= w_degNext;
            zero_poly <= w_zeroNext;
            if (w_capture) begin
                r_poly <= polynom_in;
            end
        end
    end

endmodule

// File: tb/tb_rs_degree_scan.sv
// Directed self-checking bench for rs_degree_scan: default build plus
// NCOEF=17, LANES=1 and LANES=NCOEF variants, all on a shared clock.
module tb_rs_degree_scan;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          enable = 1'b1;

    logic          start = 1'b0;
    logic [119:0]  polyIn = '0;
    logic          busy, done, zeroPoly;
    logic [4:0]    degree;

    logic          start17 = 1'b0;
    logic [101:0]  poly17 = '0;
    logic          busy17, done17, zero17;
    logic [4:0]    deg17;

    logic          startL1 = 1'b0;
    logic [119:0]  polyL1 = '0;
    logic          busyL1, doneL1, zeroL1;
    logic [4:0]    degL1;

    logic          startLN = 1'b0;
    logic [119:0]  polyLN = '0;
    logic          busyLN, doneLN, zeroLN;
    logic [4:0]    degLN;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int cnt;

    always #5 CLK = ~CLK;

    rs_degree_scan dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .start(start), .polynom_in(polyIn),
        .busy(busy), .done(done), .degree(degree), .zero_poly(zeroPoly)
    );

    rs_degree_scan #(.SYM_W(6), .NCOEF(17), .LANES(4), .DEG_W(5)) dut17 (
        .CLK(CLK), .RESET(RESET), .enable(enable), .start(start17), .polynom_in(poly17),
        .busy(busy17), .done(done17), .degree(deg17), .zero_poly(zero17)
    );

    rs_degree_scan #(.SYM_W(6), .NCOEF(20), .LANES(1), .DEG_W(5)) dutL1 (
        .CLK(CLK), .RESET(RESET), .enable(enable), .start(startL1), .polynom_in(polyL1),
        .busy(busyL1), .done(doneL1), .degree(degL1), .zero_poly(zeroL1)
    );

    rs_degree_scan #(.SYM_W(6), .NCOEF(20), .LANES(20), .DEG_W(5)) dutLN (
        .CLK(CLK), .RESET(RESET), .enable(enable), .start(startLN), .polynom_in(polyLN),
        .busy(busyLN), .done(doneLN), .degree(degLN), .zero_poly(zeroLN)
    );

    function automatic logic [119:0] coef(input int idx, input logic [5:0] val);
        logic [119:0] v;
        v = '0;
        v[idx*6 +: 6] = val;
        return v;
    endfunction

    function automatic logic pickDone(input int id);
        case (id)
            1:       return done17;
            2:       return doneL1;
            3:       return doneLN;
            default: return done;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Counts edges after the capture edge until done is seen high; -1 on timeout.
    task automatic waitDone(input int id, output int latency);
        latency = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (pickDone(id)) begin
                latency = c;
                return;
            end
        end
    endtask

    task automatic applyStimulus(input logic [119:0] poly);
        polyIn = poly;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        $display("[TB] reset phase");
        #12;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_degree", int'(degree), 0);
        checkOutput("rst_zero", int'(zeroPoly), 0);
        RESET = 1'b0;
        tick();

        // Top coefficient found in the first scanned group.
        applyStimulus(coef(19, 6'h01));
        waitDone(0, lat);
        checkOutput("t1_latency", lat, 1);
        checkOutput("t1_degree", int'(degree), 19);
        checkOutput("t1_zero", int'(zeroPoly), 0);
        checkOutput("t1_busy", int'(busy), 0);
        tick();
        checkOutput("t1_done_pulse", int'(done), 0);

        applyStimulus(coef(0, 6'h3F));
        waitDone(0, lat);
        checkOutput("t2_c0_latency", lat, 5);
        checkOutput("t2_c0_degree", int'(degree), 0);
        checkOutput("t2_c0_zero", int'(zeroPoly), 0);

        applyStimulus('0);
        waitDone(0, lat);
        checkOutput("t2_zero_latency", lat, 5);
        checkOutput("t2_zero_degree", int'(degree), 0);
        checkOutput("t2_zero_flag", int'(zeroPoly), 1);

        // Input change after capture must be ignored; previous result holds mid-scan.
        applyStimulus(coef(7, 6'h12) | coef(3, 6'h05));
        polyIn = '1;
        tick();
        checkOutput("t3_hold_zero", int'(zeroPoly), 1);
        checkOutput("t3_busy", int'(busy), 1);
        waitDone(0, lat);
        checkOutput("t3_latency", lat + 1, 4);
        checkOutput("t3_degree", int'(degree), 7);
        checkOutput("t3_zero", int'(zeroPoly), 0);

        // Two non-zero lanes in the same group: the higher index wins.
        applyStimulus(coef(9, 6'h21) | coef(10, 6'h02));
        waitDone(0, lat);
        checkOutput("grp_latency", lat, 3);
        checkOutput("grp_degree", int'(degree), 10);

        // Enable gap mid-scan, with start held high throughout the scan.
        polyIn = coef(7, 6'h12) | coef(3, 6'h05);
        start  = 1'b1;
        tick();
        polyIn = coef(19, 6'h01);
        tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("t4_busy_frozen", int'(busy), 1);
        enable = 1'b1;
        waitDone(0, lat);
        start = 1'b0;
        checkOutput("t4_latency", lat + 4, 7);
        checkOutput("t4_degree", int'(degree), 7);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) cnt++;
        end
        checkOutput("t4_no_extra_done", cnt, 0);

        // Back-to-back: start issued in the done cycle.
        applyStimulus(coef(19, 6'h01));
        waitDone(0, lat);
        checkOutput("t5_first_degree", int'(degree), 19);
        applyStimulus(coef(12, 6'h0A));
        checkOutput("t5_done_drops", int'(done), 0);
        waitDone(0, lat);
        checkOutput("t5_latency", lat, 2);
        checkOutput("t5_degree", int'(degree), 12);

        // Reset mid-scan aborts immediately and produces no later done.
        applyStimulus('0);
        tick();
        RESET = 1'b1;
        #1;
        checkOutput("t5_rst_busy", int'(busy), 0);
        checkOutput("t5_rst_done", int'(done), 0);
        checkOutput("t5_rst_degree", int'(degree), 0);
        #3;
        RESET = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) cnt++;
        end
        checkOutput("t5_rst_no_done", cnt, 0);

        // Parameter variants.
        poly17 = '0;
        poly17[16*6 +: 6] = 6'h11;
        start17 = 1'b1;
        tick();
        start17 = 1'b0;
        waitDone(1, lat);
        checkOutput("n17_latency", lat, 1);
        checkOutput("n17_degree", int'(deg17), 16);
        checkOutput("n17_zero", int'(zero17), 0);

        polyL1  = coef(5, 6'h07);
        startL1 = 1'b1;
        tick();
        startL1 = 1'b0;
        waitDone(2, lat);
        checkOutput("l1_latency", lat, 15);
        checkOutput("l1_degree", int'(degL1), 5);

        polyLN  = coef(3, 6'h30);
        startLN = 1'b1;
        tick();
        startLN = 1'b0;
        waitDone(3, lat);
        checkOutput("ln_latency", lat, 1);
        checkOutput("ln_degree", int'(degLN), 3);

        polyLN  = '0;
        startLN = 1'b1;
        tick();
        startLN = 1'b0;
        waitDone(3, lat);
        checkOutput("ln_zero_latency", lat, 1);
        checkOutput("ln_zero_flag", int'(zeroLN), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
